prog_uart_loader: RTL and testbench
===================================

PROG_UART_LOADER -- requirements
Module: prog_uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clock cycles per UART bit (115200 baud at 10 MHz).
REQ-002 Parameter ADDR_W, default 14, word-address width (16384-word instruction memory).
REQ-003 Parameter END_WORD, default 32'h00000FFF, end-of-program marker word.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 en_i  input  1  programming-mode enable; low forces loader idle.
REQ-007 rx_i  input  1  UART serial in, 8N1, LSB first, idle high; asynchronous to clk_i.
REQ-008 ready_o  output  1  loader is accepting program bytes.
REQ-009 we_o  output  1  one-cycle memory write strobe.
REQ-010 addr_o  output  ADDR_W  word address of the current write.
REQ-011 wdata_o  output  32  write data.
REQ-012 done_o  output  1  sticky: end marker received or memory full.
REQ-013 frame_err_o  output  1  sticky: at least one byte had a bad stop bit.
REQ-014 ovf_o  output  1  sticky: memory filled before the end marker arrived.

Function
REQ-015 rx_i shall pass through a 2-flop synchronizer reset to 1; all RX decisions shall use the synchronized value.
REQ-016 RX FSM states: IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE->START on synchronized rx = 0.
  - START: sample at count CLKS_PER_BIT/2; if low ->DATA, else ->IDLE (glitch, no byte).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. High -> byte valid for 1 cycle, ->IDLE. Low -> byte discarded, frame_err_o set, ->WAIT_HI.
  - WAIT_HI->IDLE on rx = 1.
REQ-017 The receiver shall decode a start bit stretched by up to 12 clock cycles beyond CLKS_PER_BIT without bit errors.
REQ-018 The RX FSM shall run only while ready_o = 1; otherwise it shall be held in IDLE.
REQ-019 Loader FSM states: L_IDLE, L_RECV, L_DONE.
  - L_IDLE->L_RECV when en_i = 1 and done_o = 0.
  - L_RECV->L_DONE on end marker or memory full.
  - Any state->L_IDLE when en_i = 0.
REQ-020 ready_o shall be 1 exactly in L_RECV, registered.
REQ-021 Bytes shall assemble MSB first: the 1st byte received becomes bits 31:24 and the 4th becomes bits 7:0; a 2-bit byte counter shall wrap 3->0.
REQ-022 On the 4th byte, if the word equals END_WORD, no write shall occur; done_o shall be set the next cycle and the state shall go to L_DONE.
REQ-023 On the 4th byte otherwise, we_o shall pulse high the next cycle with wdata_o = word and addr_o = current address; the address shall increment after the write.
REQ-024 Latency from the valid stop-bit sample of byte 4 to the we_o or done_o assertion shall be exactly 2 clock cycles.
REQ-025 A write to address 2^ADDR_W-1 shall set ovf_o and done_o and enter L_DONE; the address shall not wrap to 0.
REQ-026 A framing-error byte shall not advance the byte counter.
REQ-027 Deasserting en_i shall clear the byte counter, address, done_o, ovf_o and frame_err_o; a partial word shall be discarded and no we_o shall fire.
REQ-028 we_o shall be 0 in every cycle except REQ-023 pulses; addr_o and wdata_o shall hold their last values between writes.

Reset
REQ-029 On rst_ni = 0, asynchronously: ready_o, we_o, done_o, frame_err_o, ovf_o = 0; addr_o = 0; wdata_o = 0; both FSMs idle; byte counter = 0; synchronizer = 1.
REQ-030 On reset release, the first transition to L_RECV shall occur no earlier than the first rising edge with en_i = 1.

Verification
REQ-031 en_i = 1; send 12 34 56 78, then 00 00 0F FF -> one we_o, addr_o = 0, wdata_o = 32'h12345678; done_o = 1; ready_o = 0.
REQ-032 Send 3 words then the marker -> writes at addr_o = 0, 1, 2 with correct data; no 4th write.
REQ-033 Byte AA with stop bit 0 inside a word -> frame_err_o = 1; byte dropped; the following 4 good bytes form the word.
REQ-034 rx low pulse of 20 cycles -> no byte accepted, no error flagged.
REQ-035 en_i dropped after 2 bytes, then reasserted, then DE AD BE EF sent -> write addr_o = 0, wdata_o = 32'hDEADBEEF.
REQ-036 ADDR_W = 2; send 4 non-marker words -> writes at addr_o = 0..3, then ovf_o = 1 and done_o = 1; a 5th word is ignored.

Source files
------------

// File: rtl/prog_uart_loader.sv
// UART program loader: receives 8N1 bytes, packs them MSB-first into 32-bit
// words and streams them into instruction memory until an end marker or full.
module prog_uart_loader #(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              ovf_o
);

    localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   HALF_BIT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]   LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_RECV, L_DONE} ld_state_t;

    logic [1:0]        sync_reg;
    logic              rx_s;
    rx_state_t         rx_state_reg;
    logic [CW-1:0]     tick_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        rx_byte_reg;
    logic              byte_valid_reg;
    logic              byte_err_reg;

    ld_state_t         ld_state_reg;
    logic [1:0]        byte_cnt_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;
    logic [31:0]       word_reg;
    logic              word_pend_reg;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_reg   <= IDLE;
            tick_reg       <= '0;
            bit_idx_reg    <= '0;
            rx_byte_reg    <= '0;
            byte_valid_reg <= 1'b0;
            byte_err_reg   <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            byte_err_reg   <= 1'b0;
            if (!ready_o) begin
                rx_state_reg <= IDLE;
                tick_reg     <= '0;
            end else begin
                case (rx_state_reg)
                    IDLE: begin
                        tick_reg <= '0;
                        if (!rx_s) rx_state_reg <= START;
                    end
                    START: begin
                        // Mid-bit check rejects short low glitches.
                        if (tick_reg == HALF_BIT) begin
                            tick_reg     <= '0;
                            bit_idx_reg  <= '0;
                            rx_state_reg <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_reg <= tick_reg + CW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_reg == LAST_TICK) begin
                            tick_reg    <= '0;
                            rx_byte_reg <= {rx_s, rx_byte_reg[7:1]};
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            if (bit_idx_reg == 3'd7) rx_state_reg <= STOP;
                        end else begin
                            tick_reg <= tick_reg + CW'(1);
                        end
                    end
                    STOP: begin
                        if (tick_reg == LAST_TICK) begin
                            tick_reg <= '0;
                            if (rx_s) begin
                                byte_valid_reg <= 1'b1;
                                rx_state_reg   <= IDLE;
                            end else begin
                                byte_err_reg   <= 1'b1;
                                rx_state_reg   <= WAIT_HI;
                            end
                        end else begin
                            tick_reg <= tick_reg + CW'(1);
                        end
                    end
                    WAIT_HI: begin
                        if (rx_s) rx_state_reg <= IDLE;
                    end
                    default: rx_state_reg <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_state_reg  <= L_IDLE;
            ready_o       <= 1'b0;
            we_o          <= 1'b0;
            addr_o        <= '0;
            wdata_o       <= '0;
            done_o        <= 1'b0;
            frame_err_o   <= 1'b0;
            ovf_o         <= 1'b0;
            byte_cnt_reg  <= '0;
            addr_cnt_reg  <= '0;
            word_reg      <= '0;
            word_pend_reg <= 1'b0;
        end else begin
            we_o          <= 1'b0;
            word_pend_reg <= 1'b0;
            if (!en_i) begin
                ld_state_reg <= L_IDLE;
                ready_o      <= 1'b0;
                done_o       <= 1'b0;
                frame_err_o  <= 1'b0;
                ovf_o        <= 1'b0;
                byte_cnt_reg <= '0;
                addr_cnt_reg <= '0;
            end else begin
                case (ld_state_reg)
                    L_IDLE: begin
                        if (!done_o) begin
                            ld_state_reg <= L_RECV;
                            ready_o      <= 1'b1;
                        end
                    end
                    L_RECV: begin
                        if (byte_err_reg) frame_err_o <= 1'b1;
                        if (byte_valid_reg) begin
                            word_reg      <= {word_reg[23:0], rx_byte_reg};
                            byte_cnt_reg  <= byte_cnt_reg + 2'd1;
                            word_pend_reg <= (byte_cnt_reg == 2'd3);
                        end
                        // A completed word is committed one cycle after its last byte.
                        if (word_pend_reg) begin
                            if (word_reg == END_WORD) begin
                                done_o       <= 1'b1;
                                ready_o      <= 1'b0;
                                ld_state_reg <= L_DONE;
                            end else begin
                                we_o    <= 1'b1;
                                wdata_o <= word_reg;
                                addr_o  <= addr_cnt_reg;
                                if (addr_cnt_reg == ADDR_MAX) begin
                                    ovf_o        <= 1'b1;
                                    done_o       <= 1'b1;
                                    ready_o      <= 1'b0;
                                    ld_state_reg <= L_DONE;
                                end else begin
                                    addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
                                end
                            end
                        end
                    end
                    L_DONE: begin
                        ready_o <= 1'b0;
                    end
                    default: begin
                        ld_state_reg <= L_IDLE;
                        ready_o      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_uart_loader.sv
// Directed bench for prog_uart_loader: a default-size loader and a 4-word
// loader share the clock and reset, each with its own serial line and enable.
module tb_prog_uart_loader;

    localparam int CPB0 = 87;
    localparam int CPB1 = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0, en1, rx0, rx1;
    logic        rdy0, we0, done0, ferr0, ovf0;
    logic [13:0] addr0;
    logic [31:0] wdata0;
    logic        rdy1, we1, done1, ferr1, ovf1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;

    int n_cmp = 0;
    int n_mis = 0;

    int          wcnt0 = 0;
    int          wcnt1 = 0;
    logic [31:0] alog0 [0:31];
    logic [31:0] dlog0 [0:31];
    logic [31:0] alog1 [0:31];
    logic [31:0] dlog1 [0:31];

    always #5 clk = ~clk;

    prog_uart_loader #(.CLKS_PER_BIT(CPB0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en0), .rx_i(rx0),
        .ready_o(rdy0), .we_o(we0), .addr_o(addr0), .wdata_o(wdata0),
        .done_o(done0), .frame_err_o(ferr0), .ovf_o(ovf0)
    );

    prog_uart_loader #(.CLKS_PER_BIT(CPB1), .ADDR_W(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .rx_i(rx1),
        .ready_o(rdy1), .we_o(we1), .addr_o(addr1), .wdata_o(wdata1),
        .done_o(done1), .frame_err_o(ferr1), .ovf_o(ovf1)
    );

    // Log every cycle with a write strobe; a stuck strobe shows up as extra entries.
    always @(negedge clk) begin
        if (we0) begin
            if (wcnt0 < 32) begin
                alog0[wcnt0] = 32'(addr0);
                dlog0[wcnt0] = wdata0;
            end
            wcnt0++;
        end
        if (we1) begin
            if (wcnt1 < 32) begin
                alog1[wcnt1] = 32'(addr1);
                dlog1[wcnt1] = wdata1;
            end
            wcnt1++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic send_byte(input int which, input logic [7:0] b, input logic stop_b, input int stretch);
        int cpb;
        cpb = (which == 0) ? CPB0 : CPB1;
        drive_rx(which, 1'b0);
        wait_clk(cpb + stretch);
        for (int i = 0; i < 8; i++) begin
            drive_rx(which, b[i]);
            wait_clk(cpb);
        end
        drive_rx(which, stop_b);
        wait_clk(cpb);
        drive_rx(which, 1'b1);
        wait_clk(cpb);
    endtask

    task automatic send_word(input int which, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(which, w[8*i +: 8], 1'b1, 0);
    endtask

    task automatic wait_ready(input int which, input string tag);
        int k;
        k = 0;
        while (((which == 0) ? rdy0 : rdy1) !== 1'b1 && k < 20) begin
            wait_clk(1);
            k++;
        end
        chk(tag, 32'((which == 0) ? rdy0 : rdy1), 32'd1);
    endtask

    task automatic en_cycle0(input string tag);
        en0 = 1'b0;
        wait_clk(3);
        chk({tag, "_done_clr"}, 32'(done0), 32'd0);
        chk({tag, "_ferr_clr"}, 32'(ferr0), 32'd0);
        en0 = 1'b1;
        wait_ready(0, {tag, "_ready"});
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1;
        wait_clk(3);
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_wdata", wdata0, 32'd0);
        chk("rst_flags", {29'd0, ferr0, ovf0, rdy1}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);
        chk("no_en_ready", 32'(rdy0), 32'd0);
        en0 = 1'b1;
        wait_ready(0, "en_ready");

        // Single word then end marker
        base = wcnt0;
        send_word(0, 32'h12345678);
        send_word(0, 32'h00000FFF);
        wait_clk(10);
        chk("t31_nwr", 32'(wcnt0 - base), 32'd1);
        chk("t31_addr", alog0[base], 32'd0);
        chk("t31_data", dlog0[base], 32'h12345678);
        chk("t31_done", 32'(done0), 32'd1);
        chk("t31_ready", 32'(rdy0), 32'd0);
        chk("t31_ovf", 32'(ovf0), 32'd0);
        chk("t31_hold", {2'd0, addr0, 16'd0} ^ wdata0, 32'h12345678);

        // Three words then marker
        en_cycle0("t32");
        base = wcnt0;
        send_word(0, 32'h11223344);
        send_word(0, 32'hA5A5A5A5);
        send_word(0, 32'h00000FFE);
        send_word(0, 32'h00000FFF);
        wait_clk(10);
        chk("t32_nwr", 32'(wcnt0 - base), 32'd3);
        chk("t32_a0", alog0[base],     32'd0);
        chk("t32_d0", dlog0[base],     32'h11223344);
        chk("t32_a1", alog0[base + 1], 32'd1);
        chk("t32_d1", dlog0[base + 1], 32'hA5A5A5A5);
        chk("t32_a2", alog0[base + 2], 32'd2);
        chk("t32_d2", dlog0[base + 2], 32'h00000FFE);
        chk("t32_done", 32'(done0), 32'd1);

        // Framing error byte inside a word
        en_cycle0("t33");
        base = wcnt0;
        send_byte(0, 8'hAA, 1'b0, 0);
        wait_clk(5);
        chk("t33_ferr", 32'(ferr0), 32'd1);
        chk("t33_nwr0", 32'(wcnt0 - base), 32'd0);
        send_word(0, 32'hC0FFEE01);
        wait_clk(10);
        chk("t33_nwr", 32'(wcnt0 - base), 32'd1);
        chk("t33_addr", alog0[base], 32'd0);
        chk("t33_data", dlog0[base], 32'hC0FFEE01);
        chk("t33_ferr_sticky", 32'(ferr0), 32'd1);
        chk("t33_done", 32'(done0), 32'd0);

        // 20-cycle low glitch
        en_cycle0("t34");
        base = wcnt0;
        rx0 = 1'b0;
        wait_clk(20);
        rx0 = 1'b1;
        wait_clk(3 * CPB0);
        chk("t34_ferr", 32'(ferr0), 32'd0);
        chk("t34_ready", 32'(rdy0), 32'd1);
        send_word(0, 32'h01020304);
        wait_clk(10);
        chk("t34_nwr", 32'(wcnt0 - base), 32'd1);
        chk("t34_addr", alog0[base], 32'd0);
        chk("t34_data", dlog0[base], 32'h01020304);

        // Partial word aborted by en drop, then stretched start bit
        en_cycle0("t35");
        base = wcnt0;
        send_byte(0, 8'hDE, 1'b1, 0);
        send_byte(0, 8'hAD, 1'b1, 0);
        en0 = 1'b0;
        wait_clk(4);
        chk("t35_nwr_abort", 32'(wcnt0 - base), 32'd0);
        chk("t35_ready_off", 32'(rdy0), 32'd0);
        en0 = 1'b1;
        wait_ready(0, "t35_ready");
        send_byte(0, 8'hDE, 1'b1, 12);
        send_byte(0, 8'hAD, 1'b1, 0);
        send_byte(0, 8'hBE, 1'b1, 0);
        send_byte(0, 8'hEF, 1'b1, 0);
        wait_clk(10);
        chk("t35_nwr", 32'(wcnt0 - base), 32'd1);
        chk("t35_addr", alog0[base], 32'd0);
        chk("t35_data", dlog0[base], 32'hDEADBEEF);

        // Fill a 4-word memory
        en1 = 1'b1;
        wait_ready(1, "t36_ready");
        base = wcnt1;
        send_word(1, 32'h10000001);
        send_word(1, 32'h20000002);
        send_word(1, 32'h30000003);
        send_word(1, 32'h40000004);
        wait_clk(10);
        chk("t36_nwr", 32'(wcnt1 - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t36_a%0d", i), alog1[base + i], 32'(i));
            chk($sformatf("t36_d%0d", i), dlog1[base + i], 32'h10000001 * (i + 1) + 32'h00000000);
        end
        chk("t36_ovf", 32'(ovf1), 32'd1);
        chk("t36_done", 32'(done1), 32'd1);
        chk("t36_ready", 32'(rdy1), 32'd0);
        chk("t36_addr_hold", 32'(addr1), 32'd3);
        send_word(1, 32'h50000005);
        wait_clk(10);
        chk("t36_5th_ignored", 32'(wcnt1 - base), 32'd4);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wdata", wdata0, 32'd0);
        chk("arst_ovf_done", {30'd0, ovf1, done1}, 32'd0);
        chk("arst_addr", 32'(addr1), 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
